bht_predict_unit: RTL

- Fetch-side branch predictor with a table of 2-bit saturating counters, indexed by PC.
- Replaces the single global predictor with per-PC history.
- Fetch pushes each predicted branch into a small in-order tracking queue. Execute pops the oldest entry when the branch resolves.
- On pop: the block updates the indexed counter, flags mispredictions, and flushes the wrong-path entries still in the queue.

---
 rtl/bht_predict_unit_pkg.sv | 30 +++
 rtl/bht_predict_unit_if.sv | 28 ++
 rtl/bht_track_queue.sv | 67 ++++++
 rtl/bht_predict_unit.sv | 104 ++++++++++
 4 files changed

// File: rtl/bht_predict_unit_pkg.sv
// Shared definitions for the per-PC branch history table predictor.
//   - 2-bit saturating counter state constants and next-state function
//   - bht_entry_t: one in-flight branch tracked between fetch and execute
package bht_predict_unit_pkg;

    // 2-bit counter states; the MSB is the taken prediction.
    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    // Widest index a 16-bit, 2-byte aligned PC can supply (f_pc[15:1]).
    // Entries carry the full width so the struct does not depend on the
    // table size; unused upper bits are trimmed by synthesis.
    localparam int unsigned MaxIdxBits = 15;

    typedef struct packed {
        logic [MaxIdxBits-1:0] idx;
        logic                  pred;
    } bht_entry_t;

    // Move one step toward the resolved outcome, saturating at SNT/ST.
    function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
        if (taken) begin
            return (ctr == ST) ? ST : ctr + 2'd1;
        end
        return (ctr == SNT) ? SNT : ctr - 2'd1;
    endfunction

endpackage

// File: rtl/bht_predict_unit_if.sv
// Fetch/execute bus of the BHT predictor.
//   master: fetch + execute side (drives f_valid, f_is_branch, f_pc, x_resolve, x_taken)
//   slave : predictor (drives f_pred_taken, f_stall, x_mispredict, x_q_empty, stats)
interface bht_predict_unit_if #(
    parameter int unsigned CNT_W = 16
) ();
    logic             f_valid;
    logic             f_is_branch;
    logic [15:0]      f_pc;
    logic             f_pred_taken;
    logic             f_stall;
    logic             x_resolve;
    logic             x_taken;
    logic             x_mispredict;
    logic             x_q_empty;
    logic [CNT_W-1:0] branch_cnt;
    logic [CNT_W-1:0] mispred_cnt;

    modport master (
        output f_valid, f_is_branch, f_pc, x_resolve, x_taken,
        input  f_pred_taken, f_stall, x_mispredict, x_q_empty, branch_cnt, mispred_cnt
    );

    modport slave (
        input  f_valid, f_is_branch, f_pc, x_resolve, x_taken,
        output f_pred_taken, f_stall, x_mispredict, x_q_empty, branch_cnt, mispred_cnt
    );
endinterface

// File: rtl/bht_track_queue.sv
// In-order queue of predicted branches awaiting resolution.
//   push_i/entry_i : enqueue at tail (caller guarantees a free slot or a same-cycle pop)
//   pop_i          : dequeue head (caller guarantees non-empty)
//   flush_i        : after this edge the queue is empty (applied together with pop)
//   head_o         : oldest entry, valid when !empty_o
//   full_o/empty_o : occupancy flags
module bht_track_queue
    import bht_predict_unit_pkg::*;
#(
    parameter int unsigned Q_DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push_i,
    input  bht_entry_t entry_i,
    input  logic       pop_i,
    input  logic       flush_i,
    output bht_entry_t head_o,
    output logic       full_o,
    output logic       empty_o
);
    localparam int unsigned PtrW = $clog2(Q_DEPTH);

    // Pointers carry an extra wrap bit to tell full from empty.
    logic [PtrW:0] head_q, head_d;
    logic [PtrW:0] tail_q, tail_d;
    bht_entry_t    mem_q [Q_DEPTH];
    bht_entry_t    mem_d [Q_DEPTH];

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        mem_d  = mem_q;
        if (pop_i) begin
            head_d = head_q + 1'b1;
        end
        // When full with a same-cycle pop, tail aliases head: head is read
        // combinationally before the edge, so overwriting it is safe.
        if (push_i) begin
            mem_d[tail_q[PtrW-1:0]] = entry_i;
            tail_d = tail_q + 1'b1;
        end
        if (flush_i) begin
            tail_d = head_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
            for (int i = 0; i < int'(Q_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            mem_q  <= mem_d;
        end
    end

    assign head_o  = mem_q[head_q[PtrW-1:0]];
    assign empty_o = (head_q == tail_q);
    assign full_o  = (head_q[PtrW] != tail_q[PtrW]) &&
                     (head_q[PtrW-1:0] == tail_q[PtrW-1:0]);

endmodule

// File: rtl/bht_predict_unit.sv
// Fetch-side branch predictor: table of 2-bit saturating counters indexed by
// f_pc[IDX_BITS:1], with an in-order tracking queue between fetch and execute.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : fetch lookup/push, execute resolve, mispredict and statistics
module bht_predict_unit
    import bht_predict_unit_pkg::*;
#(
    parameter int unsigned IDX_BITS = 4,
    parameter int unsigned Q_DEPTH  = 2,
    parameter int unsigned CNT_W    = 16
) (
    input logic               clk,
    input logic               rst,
    bht_predict_unit_if.slave bus
);
    localparam int unsigned TblSize = 2 ** IDX_BITS;

    logic [1:0]          table_q [TblSize];
    logic [1:0]          table_d [TblSize];
    logic [CNT_W-1:0]    branch_cnt_q, branch_cnt_d;
    logic [CNT_W-1:0]    mispred_cnt_q, mispred_cnt_d;

    logic [IDX_BITS-1:0] f_idx;
    logic [IDX_BITS-1:0] h_idx;
    logic                f_hit;
    logic                q_push;
    logic                q_pop;
    logic                q_full;
    logic                q_empty;
    logic                mispredict;
    bht_entry_t          push_entry;
    bht_entry_t          head;

    logic unused_bits;
    assign unused_bits = ^{bus.f_pc[0], head.idx};

    assign f_idx = bus.f_pc[IDX_BITS:1];
    assign h_idx = head.idx[IDX_BITS-1:0];
    assign f_hit = bus.f_valid && bus.f_is_branch;

    // Resolve while empty is ignored entirely.
    assign q_pop      = bus.x_resolve && !q_empty;
    assign mispredict = q_pop && (head.pred != bus.x_taken);

    always_comb begin
        bus.f_pred_taken = f_hit && table_q[f_idx][1];
        // A same-cycle pop frees a slot, so a full queue only stalls without one.
        bus.f_stall      = f_hit && q_full && !bus.x_resolve;
        // A push alongside a mispredict is wrong-path and is dropped.
        q_push           = f_hit && !bus.f_stall && !mispredict;
        push_entry       = '0;
        push_entry.idx   = MaxIdxBits'(f_idx);
        push_entry.pred  = bus.f_pred_taken;
    end

    always_comb begin
        table_d       = table_q;
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (q_pop) begin
            table_d[h_idx] = ctr_next(table_q[h_idx], bus.x_taken);
            if (branch_cnt_q != '1) begin
                branch_cnt_d = branch_cnt_q + 1'b1;
            end
            if (mispredict && (mispred_cnt_q != '1)) begin
                mispred_cnt_d = mispred_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(TblSize); i++) begin
                table_q[i] <= SNT;
            end
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            table_q       <= table_d;
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    bht_track_queue #(
        .Q_DEPTH (Q_DEPTH)
    ) u_queue (
        .clk     (clk),
        .rst     (rst),
        .push_i  (q_push),
        .entry_i (push_entry),
        .pop_i   (q_pop),
        .flush_i (mispredict),
        .head_o  (head),
        .full_o  (q_full),
        .empty_o (q_empty)
    );

    assign bus.x_mispredict = mispredict;
    assign bus.x_q_empty    = q_empty;
    assign bus.branch_cnt   = branch_cnt_q;
    assign bus.mispred_cnt  = mispred_cnt_q;

endmodule
